// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the source side of the toggle req/ack word handshake.
// Holds the FSM state encoding and the default word/synchroniser sizes.
package cdc_handshake_tx_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/cdc_sync_rst.sv
// Multi-flop single-bit synchroniser with asynchronous active-high reset to 0.
// Brings the destination's ack toggle into the source clock domain.
module cdc_sync_rst #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Launching end of a two-phase toggle handshake: captures a word, holds it on
// tx_data, toggles tx_req a cycle later and waits for the synchronised ack.
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int STAGES  = DEFAULT_STAGES,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             ack_in,
    output logic             done,
    output logic             ack_err,
    output logic             timeout
);

    // A zero-width counter is illegal, so a disabled timeout keeps one idle bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q;
    logic [WIDTH-1:0]  data_q;
    logic              req_q;
    logic              ack_prev_q;
    logic              done_q;
    logic              ack_err_q;
    logic              timeout_q;
    logic [CW-1:0]     cnt_q;
    logic              ack_s;
    logic              accept;

    cdc_sync_rst #(
        .STAGES(STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d_i(ack_in),
        .q_o(ack_s)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            req_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ack_prev_q <= ack_s;
            done_q     <= 1'b0;
            // An ack edge is only expected while a request is outstanding.
            ack_err_q  <= (ack_s != ack_prev_q) && (state_q != ST_WAIT);

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q    <= in_data;
                        timeout_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    req_q   <= ~req_q;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (TIMEOUT > 0) begin
                        if (cnt_q != CW'(TIMEOUT)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (cnt_q == CW'(TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                    if (ack_s == req_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data = data_q;
    assign tx_req  = req_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed and randomised transfers
// against an edge-count model of request, acknowledge, done and timeout.
module tb_cdc_handshake_tx;

    localparam int WIDTH   = 8;
    localparam int STAGES  = 2;
    localparam int TIMEOUT = 10;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req;
    logic             ack_in;
    logic             done;
    logic             ack_err;
    logic             timeout;

    int               errors;
    int               checks;
    int               cycleCount;
    logic [WIDTH-1:0] expData;
    logic             expReq;
    logic             expTimeout;

    cdc_handshake_tx #(
        .WIDTH(WIDTH),
        .STAGES(STAGES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .ack_in(ack_in),
        .done(done),
        .ack_err(ack_err),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cycleCount++;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expReady,
                            input logic expDone, input logic expErr);
        checkOutput({tag, " tx_data"}, 32'(tx_data), 32'(expData));
        checkOutput({tag, " tx_req"}, 32'(tx_req), 32'(expReq));
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(expReady));
        checkOutput({tag, " done"}, 32'(done), 32'(expDone));
        checkOutput({tag, " ack_err"}, 32'(ack_err), 32'(expErr));
        checkOutput({tag, " timeout"}, 32'(timeout), 32'(expTimeout));
    endtask

    // One full transfer. Edge 0 is the accept, edge 1 toggles the request, the
    // destination answers right after edge 1+ackDelay, and the acknowledge then
    // needs STAGES edges to cross plus one edge to register done.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input int ackDelay,
                                 input bit holdValid, output int acceptCycle);
        int doneEdge;
        in_valid = 1'b1;
        in_data  = data;
        tick();
        acceptCycle = cycleCount;
        expData     = data;
        expTimeout  = 1'b0;
        if (holdValid) begin
            in_data = 8'hFF;
        end else begin
            in_valid = 1'b0;
        end
        checkAll("accept", 1'b0, 1'b0, 1'b0);
        tick();
        expReq = ~expReq;
        checkAll("req", 1'b0, 1'b0, 1'b0);
        doneEdge = 1 + ackDelay + STAGES + 1;
        for (int k = 1; k < doneEdge; k++) begin
            if (k == 1 + ackDelay) begin
                ack_in = expReq;
            end
            tick();
            if (k >= TIMEOUT) begin
                expTimeout = 1'b1;
            end
            checkAll((k + 1 == doneEdge) ? "done" : "wait", k + 1 == doneEdge,
                     k + 1 == doneEdge, 1'b0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int acc0;
        int acc1;
        errors     = 0;
        checks     = 0;
        cycleCount = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        ack_in     = 1'b0;
        expData    = '0;
        expReq     = 1'b0;
        expTimeout = 1'b0;

        #3;
        checkAll("reset", 1'b1, 1'b0, 1'b0);
        #4 rst = 1'b0;
        tick();
        checkAll("idle", 1'b1, 1'b0, 1'b0);

        $display("[TB] single transfer");
        applyStimulus(8'hA5, 0, 1'b0, acc0);

        $display("[TB] back-to-back with in_valid held");
        applyStimulus(8'h01, 0, 1'b1, acc0);
        applyStimulus(8'h02, 0, 1'b1, acc1);
        checkOutput("b2b spacing 1-2", 32'(acc1 - acc0), 32'(3 + STAGES));
        applyStimulus(8'h03, 0, 1'b1, acc0);
        checkOutput("b2b spacing 2-3", 32'(acc0 - acc1), 32'(3 + STAGES));

        $display("[TB] slow ack past timeout");
        applyStimulus(8'h5A, 20, 1'b0, acc0);
        applyStimulus(8'h66, 1, 1'b0, acc0);

        $display("[TB] spurious ack in idle");
        for (int pass = 0; pass < 2; pass++) begin
            ack_in = ~ack_in;
            for (int c = 1; c <= STAGES + 2; c++) begin
                tick();
                checkAll("spurious", 1'b1, 1'b0, c == STAGES + 1);
            end
        end
        applyStimulus(8'h77, 3, 1'b0, acc0);

        $display("[TB] reset during wait");
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid   = 1'b0;
        expData    = 8'h3C;
        expTimeout = 1'b0;
        checkAll("rstmid accept", 1'b0, 1'b0, 1'b0);
        tick();
        expReq = ~expReq;
        checkAll("rstmid req", 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= TIMEOUT + 2; k++) begin
            tick();
            if (k - 1 >= TIMEOUT) begin
                expTimeout = 1'b1;
            end
            checkAll("rstmid wait", 1'b0, 1'b0, 1'b0);
        end
        #2 rst = 1'b1;
        ack_in     = 1'b0;
        expReq     = 1'b0;
        expData    = '0;
        expTimeout = 1'b0;
        #1;
        checkAll("rstmid async", 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        #3 rst = 1'b0;
        tick();
        checkAll("rstmid release", 1'b1, 1'b0, 1'b0);

        $display("[TB] randomised transfers");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(WIDTH'($urandom), int'($urandom_range(0, 14)),
                          1'($urandom_range(0, 1)), acc0);
        end
        tick();
        checkAll("final idle", 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
